// File: rtl/ex_divider_unit_pkg.sv
// Shared types and constants for the EX-stage iterative RV32M divider.
package ex_divider_unit_pkg;

  localparam int DIV_XLEN           = 32;
  localparam int DIV_BITS_PER_CYCLE = 1;
  localparam int DIV_ITERS          = DIV_XLEN / DIV_BITS_PER_CYCLE;

  localparam logic [DIV_XLEN-1:0] DIV_OVERFLOW_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_divider_unit_if.sv
// EX-stage divider bundle: the pipeline side (master) drives the instruction and
// controller inputs, the divider (slave) returns the stall request and result.
interface ex_divider_unit_if #(
  parameter int XLEN = ex_divider_unit_pkg::DIV_XLEN
);
  import ex_divider_unit_pkg::*;

  logic            enable;
  div_op_e         op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            exStall;
  logic            flush;
  logic            stallReq;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output enable, op, srcA, srcB, exStall, flush,
    input  stallReq, done, result
  );

  modport slave (
    input  enable, op, srcA, srcB, exStall, flush,
    output stallReq, done, result
  );

endinterface

// File: rtl/ex_divider_unit_div_step.sv
// Combinational restoring-division slice: retires BITS_PER_CYCLE quotient bits
// from a 2*XLEN partial remainder whose low half still holds unconsumed dividend bits.
module ex_divider_unit_div_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN-1:0] rem_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN-1:0] rem_o,
  output logic [XLEN-1:0]   quo_o
);

  logic [2*XLEN-1:0] rem_v;
  logic [XLEN-1:0]   quo_v;
  logic [XLEN:0]     trial;

  // NOTE: blocking assignments here chain the steps within one evaluation;
  // each variable gets a value up front so no latch is inferred.
  always_comb begin
    rem_v = rem_i;
    quo_v = quo_i;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      // The bit shifted out of the top is kept as the trial's MSB.
      trial = {rem_v[2*XLEN-1], rem_v[2*XLEN-2:XLEN-1]} - {1'b0, divisor_i};
      rem_v = rem_v << 1;
      if (!trial[XLEN]) begin
        rem_v[2*XLEN-1:XLEN] = trial[XLEN-1:0];
      end
      quo_v = {quo_v[XLEN-2:0], ~trial[XLEN]};
    end
    rem_o = rem_v;
    quo_o = quo_v;
  end

endmodule

// File: rtl/ex_divider_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit in EX; raises stallReq to hold the
// upstream pipeline while it iterates and presents a registered result in DONE.
module ex_divider_unit
  import ex_divider_unit_pkg::*;
#(
  parameter int XLEN           = DIV_XLEN,
  parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
  input logic               clk,
  input logic               rst,
  ex_divider_unit_if.slave  bus
);

  localparam int                ITERS    = XLEN / BITS_PER_CYCLE;
  localparam int                CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [XLEN-1:0]   MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;

  logic [2*XLEN-1:0] rem_step;
  logic [XLEN-1:0]   quo_step;
  logic              is_signed, sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b, quo_fix, rem_fix;

  ex_divider_unit_div_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_step),
    .quo_o     (quo_step)
  );

  assign is_signed = op_is_signed(bus.op);
  assign sign_a    = is_signed & bus.srcA[XLEN-1];
  assign sign_b    = is_signed & bus.srcB[XLEN-1];
  assign abs_a     = sign_a ? -bus.srcA : bus.srcA;
  assign abs_b     = sign_b ? -bus.srcB : bus.srcB;

  // Sign fix-up applies to the values the final step produces, so the result
  // register is written on the same edge that enters DONE.
  assign quo_fix = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix = neg_rem_q ? -rem_step[2*XLEN-1:XLEN] : rem_step[2*XLEN-1:XLEN];

  assign bus.stallReq = rst & bus.enable & ~bus.flush & (state_q != DONE);
  assign bus.done     = (state_q == DONE) & ~bus.flush;
  assign bus.result   = result_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.enable) begin
            is_rem_d = op_is_rem(bus.op);
            if (bus.srcB == '0) begin
              result_d = op_is_rem(bus.op) ? bus.srcA : '1;
              state_d  = DONE;
            end else if (is_signed && (bus.srcA == MIN_INT) && (bus.srcB == '1)) begin
              result_d = op_is_rem(bus.op) ? '0 : MIN_INT;
              state_d  = DONE;
            end else begin
              rem_d     = {{XLEN{1'b0}}, abs_a};
              quo_d     = '0;
              dvsr_d    = abs_b;
              neg_quo_d = sign_a ^ sign_b;
              neg_rem_d = sign_a;
              cnt_d     = CNT_LAST;
              state_d   = BUSY;
            end
          end
        end
        BUSY: begin
          // Losing enable mid-divide means the instruction vanished: abandon it.
          if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == '0) begin
              result_d = is_rem_q ? rem_fix : quo_fix;
              state_d  = DONE;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (!bus.exStall) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

endmodule

// File: tb/tb_ex_divider_unit.sv
// Self-checking bench for ex_divider_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_ex_divider_unit;
  import ex_divider_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int LATENCY = DIV_ITERS + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ex_divider_unit_if #(.XLEN(XLEN)) bus ();

  ex_divider_unit #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_overflow(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    return ((op == OP_DIV) || (op == OP_REM)) && (a == DIV_OVERFLOW_DIVIDEND) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic want_rem;
    want_rem = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0)              return want_rem ? a : 32'hFFFF_FFFF;
    if (is_overflow(op, a, b))   return want_rem ? 32'd0 : DIV_OVERFLOW_DIVIDEND;
    if ((op == OP_DIV) || (op == OP_REM))
      return want_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return want_rem ? (a % b) : (a / b);
  endfunction

  // One full transaction; hold>0 keeps exStall high for that many DONE cycles.
  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp_res;
    int          exp_stall;
    int          stalls;
    int          cyc;
    exp_res   = ref_result(op, a, b);
    exp_stall = ((b == 32'd0) || is_overflow(op, a, b)) ? 1 : LATENCY;
    stalls    = 0;
    cyc       = 0;
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.op      = op;
    bus.srcA    = a;
    bus.srcB    = b;
    bus.flush   = 1'b0;
    bus.exStall = (hold > 0);
    #1;
    while (!bus.done && cyc < 200) begin
      if (bus.stallReq) stalls++;
      @(negedge clk);
      cyc++;
      #1;
    end
    check({tag, ".done"},         32'(bus.done), 32'd1);
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, ".stall_in_done"}, 32'(bus.stallReq), 32'd0);
    check({tag, ".result"},       bus.result, exp_res);
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (k == hold) bus.exStall = 1'b0;
      #1;
      check({tag, ".hold_done"},   32'(bus.done), 32'd1);
      check({tag, ".hold_result"}, bus.result, exp_res);
      check({tag, ".hold_stall"},  32'(bus.stallReq), 32'd0);
    end
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.exStall = 1'b0;
    #1;
    check({tag, ".idle_after"}, 32'(bus.done), 32'd0);
  endtask

  // Starts an operation and leaves it running for 'cycles' BUSY cycles.
  task automatic start_busy(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input int cycles);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.op      = op;
    bus.srcA    = a;
    bus.srcB    = b;
    bus.flush   = 1'b0;
    bus.exStall = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.op      = OP_DIV;
    bus.srcA    = '0;
    bus.srcB    = '0;
    bus.exStall = 1'b0;
    bus.flush   = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset.done",     32'(bus.done), 32'd0);
    check("reset.result",   bus.result, 32'd0);
    check("reset.stallReq", 32'(bus.stallReq), 32'd0);

    run_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 0);
    run_op("remu_100_7",  OP_REMU, 32'd100, 32'd7, 0);
    run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_by_zero", OP_DIV,  32'd1234, 32'd0, 0);
    run_op("remu_5_0",    OP_REMU, 32'd5, 32'd0, 0);
    run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_5_m3",    OP_REM,  32'd5, 32'hFFFF_FFFD, 0);

    // Flush on BUSY cycle 10, then a fresh divide must take the full latency.
    start_busy(OP_DIVU, 32'd100, 32'd7, 10);
    bus.flush = 1'b1;
    #1;
    check("flush.stallReq", 32'(bus.stallReq), 32'd0);
    check("flush.done",     32'(bus.done), 32'd0);
    run_op("after_flush", OP_DIVU, 32'd9, 32'd3, 0);

    // enable vanishing mid-divide aborts the operation.
    start_busy(OP_DIV, 32'hFFFF_0000, 32'd17, 5);
    bus.enable = 1'b0;
    #1;
    check("abort.stallReq", 32'(bus.stallReq), 32'd0);
    run_op("after_abort", OP_REM, 32'd1000, 32'd33, 0);

    run_op("exstall_hold", OP_DIVU, 32'd200, 32'd9, 4);

    // Reset during BUSY wins over a simultaneous flush.
    start_busy(OP_DIVU, 32'd77, 32'd5, 5);
    rst       = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    rst        = 1'b1;
    bus.flush  = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("rst_busy.done",     32'(bus.done), 32'd0);
    check("rst_busy.result",   bus.result, 32'd0);
    check("rst_busy.stallReq", 32'(bus.stallReq), 32'd0);
    run_op("after_rst", OP_DIVU, 32'd77, 32'd5, 0);

    for (int i = 0; i < 24; i++) begin
      div_op_e     op;
      logic [31:0] a, b;
      int          mode;
      op   = div_op_e'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = DIV_OVERFLOW_DIVIDEND; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: begin a = -$urandom_range(0, 50); b = -$urandom_range(1, 9); end
        4: b = $urandom_range(1, 255);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
